// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Round-robin arbiter sharing the single write port of the CPU register bank
// between four requesters (0: ALU writeback, 1: load unit, 2: immediate
// loader, 3: debug port). At most one request wins per clock; the winning
// address/data are registered onto the bank write port and a one-cycle
// acknowledge is returned to the winner.
//
// Ports:
//   CLK    in   system clock, posedge
//   RST    in   asynchronous active-high reset
//   HOLD   in   stall, blocks new grants while high
//   REQ    in   [3:0] request per requester
//   ADDR   in   [4*ADDR_W-1:0] packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   DATA   in   [4*DATA_W-1:0] packed data, requester i at [i*DATA_W +: DATA_W]
//   WE     out  registered bank write enable
//   WADDR  out  registered bank write address
//   WDATA  out  registered bank write data
//   ACK    out  [3:0] registered one-hot acknowledge
//   GNT_ID out  [1:0] index of the granted requester, valid when WE=1
//   PTR    out  [1:0] round-robin priority pointer
module reg_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                HOLD,
    input  logic [3:0]          REQ,
    input  logic [4*ADDR_W-1:0] ADDR,
    input  logic [4*DATA_W-1:0] DATA,
    output logic                WE,
    output logic [ADDR_W-1:0]   WADDR,
    output logic [DATA_W-1:0]   WDATA,
    output logic [3:0]          ACK,
    output logic [1:0]          GNT_ID,
    output logic [1:0]          PTR
);

    logic [3:0] elig;
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;

    // A requester acknowledged this cycle may still hold REQ; masking it
    // prevents a second write of the same transaction.
    assign elig = REQ & ~ACK;

    // Scan PTR, PTR+1, PTR+2, PTR+3 (2-bit wrap) and take the first eligible.
    always_comb begin
        found = 1'b0;
        win   = PTR;
        idx   = PTR;
        for (int i = 0; i < 4; i++) begin
            idx = PTR + 2'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WE     <= 1'b0;
            WADDR  <= '0;
            WDATA  <= '0;
            ACK    <= 4'b0000;
            GNT_ID <= 2'd0;
            PTR    <= 2'd0;
        end else if (!HOLD && found) begin
            WE     <= 1'b1;
            WADDR  <= ADDR[int'(win)*ADDR_W +: ADDR_W];
            WDATA  <= DATA[int'(win)*DATA_W +: DATA_W];
            ACK    <= 4'b0001 << win;
            GNT_ID <= win;
            PTR    <= win + 2'd1;
        end else begin
            // Address, data, id and pointer hold; only the strobes drop.
            WE  <= 1'b0;
            ACK <= 4'b0000;
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic                CLK;
    logic                RST;
    logic                HOLD;
    logic [3:0]          REQ;
    logic [4*ADDR_W-1:0] ADDR;
    logic [4*DATA_W-1:0] DATA;
    logic                WE;
    logic [ADDR_W-1:0]   WADDR;
    logic [DATA_W-1:0]   WDATA;
    logic [3:0]          ACK;
    logic [1:0]          GNT_ID;
    logic [1:0]          PTR;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [1:0]        id;
        logic [3:0]        ack;
        logic [1:0]        ptr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    reg_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .HOLD   (HOLD),
        .REQ    (REQ),
        .ADDR   (ADDR),
        .DATA   (DATA),
        .WE     (WE),
        .WADDR  (WADDR),
        .WDATA  (WDATA),
        .ACK    (ACK),
        .GNT_ID (GNT_ID),
        .PTR    (PTR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_slice(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        ADDR[i*ADDR_W +: ADDR_W] = a;
        DATA[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [1:0] id, input logic [3:0] ack, input logic [1:0] ptr);
        exp_t e;
        e.a = a; e.d = d; e.id = id; e.ack = ack; e.ptr = ptr;
        exp_q.push_back(e);
    endtask

    task automatic tick(input logic exp_we, input string name);
        @(posedge CLK);
        #1;
        chk(name, 32'(WE), 32'(exp_we));
    endtask

    // Monitor: every written cycle is popped against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (WE) begin
                    chk("ack_onehot", 32'($onehot(ACK)), 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("waddr",  32'(WADDR),  32'(e.a));
                        chk("wdata",  32'(WDATA),  32'(e.d));
                        chk("gnt_id", 32'(GNT_ID), 32'(e.id));
                        chk("ack",    32'(ACK),    32'(e.ack));
                        chk("ptr",    32'(PTR),    32'(e.ptr));
                    end
                end else begin
                    chk("ack_idle", 32'(ACK), 32'd0);
                end
            end
        end
    end

    initial begin
        RST  = 1'b1;
        HOLD = 1'b0;
        REQ  = 4'b0000;
        ADDR = '0;
        DATA = '0;
        #1;
        chk("rst_we",     32'(WE),     32'd0);
        chk("rst_ack",    32'(ACK),    32'd0);
        chk("rst_ptr",    32'(PTR),    32'd0);
        chk("rst_waddr",  32'(WADDR),  32'd0);
        chk("rst_wdata",  32'(WDATA),  32'd0);
        chk("rst_gnt_id", 32'(GNT_ID), 32'd0);
        #11;
        RST = 1'b0;
        tick(1'b0, "idle_we");

        // Single requester 2 held: writes on alternate cycles.
        set_slice(2, 3'd5, 8'hA5);
        REQ = 4'b0100;
        push(3'd5, 8'hA5, 2'd2, 4'b0100, 2'd3);
        push(3'd5, 8'hA5, 2'd2, 4'b0100, 2'd3);
        tick(1'b1, "single_we1");
        chk("single_ptr", 32'(PTR), 32'd3);
        tick(1'b0, "single_we0");
        tick(1'b1, "single_we1b");
        REQ = 4'b0000;
        tick(1'b0, "single_end");

        // Reset asserted mid-grant, between edges.
        set_slice(1, 3'd6, 8'hC1);
        REQ = 4'b0010;
        push(3'd6, 8'hC1, 2'd1, 4'b0010, 2'd2);
        tick(1'b1, "pre_rst_we");
        @(negedge CLK);
        #1;
        RST = 1'b1;
        REQ = 4'b0000;
        #1;
        chk("midrst_we",     32'(WE),     32'd0);
        chk("midrst_ack",    32'(ACK),    32'd0);
        chk("midrst_ptr",    32'(PTR),    32'd0);
        chk("midrst_waddr",  32'(WADDR),  32'd0);
        chk("midrst_gnt_id", 32'(GNT_ID), 32'd0);
        #1;
        RST = 1'b0;
        tick(1'b0, "post_rst_we");

        // Full contention from PTR=0: 0,1,2,3,0,1,2,3 one per cycle.
        for (int i = 0; i < 4; i++) set_slice(i, 3'(7 - i), 8'hC0 + 8'(i));
        REQ = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            push(3'(7 - (k % 4)), 8'hC0 + 8'(k % 4), 2'(k % 4), 4'b0001 << (k % 4), 2'((k + 1) % 4));
        end
        for (int k = 0; k < 8; k++) tick(1'b1, "contend_we");
        REQ = 4'b0000;
        tick(1'b0, "contend_end");
        chk("contend_ptr", 32'(PTR), 32'd0);

        // Rotation: bring PTR to 2, then REQ=0011 grants 0 then 1.
        REQ = 4'b0010;
        push(3'd6, 8'hC1, 2'd1, 4'b0010, 2'd2);
        tick(1'b1, "rot_setup_we");
        REQ = 4'b0000;
        tick(1'b0, "rot_setup_end");
        chk("rot_ptr2", 32'(PTR), 32'd2);
        REQ = 4'b0011;
        push(3'd7, 8'hC0, 2'd0, 4'b0001, 2'd1);
        push(3'd6, 8'hC1, 2'd1, 4'b0010, 2'd2);
        tick(1'b1, "rot_we_a");
        chk("rot_ptr_a", 32'(PTR), 32'd1);
        tick(1'b1, "rot_we_b");
        chk("rot_ptr_b", 32'(PTR), 32'd2);
        REQ = 4'b0000;
        tick(1'b0, "rot_end");

        // HOLD blocks grants and freezes PTR.
        set_slice(0, 3'd6, 8'h3C);
        HOLD = 1'b1;
        REQ  = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, "hold_we");
            chk("hold_ack", 32'(ACK), 32'd0);
            chk("hold_ptr", 32'(PTR), 32'd2);
        end
        HOLD = 1'b0;
        push(3'd6, 8'h3C, 2'd0, 4'b0001, 2'd1);
        tick(1'b1, "hold_release_we");
        REQ = 4'b0000;
        tick(1'b0, "hold_end");

        // Mask: REQ[3] held through grant edge and ACK cycle -> one write.
        set_slice(3, 3'd4, 8'hC3);
        REQ = 4'b1000;
        push(3'd4, 8'hC3, 2'd3, 4'b1000, 2'd0);
        tick(1'b1, "mask_we1");
        chk("mask_ack1", 32'(ACK), 32'h8);
        tick(1'b0, "mask_we0");
        chk("mask_ack0", 32'(ACK), 32'd0);
        REQ = 4'b0000;
        tick(1'b0, "mask_idle1");
        tick(1'b0, "mask_idle2");

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
